// File: rtl/abs_diff_bmf_pkg.sv
// Shared constants and types for the BMF decoder: default sizes, FSM states
// and the reset-time basis matrix.
package abs_diff_bmf_pkg;

    localparam int unsigned BMF_K = 2;
    localparam int unsigned BMF_M = 5;

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } bmf_state_t;

    localparam logic [4:0] BMF_DEF_ROW0 = 5'b01101;
    localparam logic [4:0] BMF_DEF_ROW1 = 5'b10000;

    // Rows above 1 default to zero; callers size the result down to M.
    function automatic logic [31:0] bmf_default_row(input int unsigned row);
        case (row)
            0:       return 32'(BMF_DEF_ROW0);
            1:       return 32'(BMF_DEF_ROW1);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/bmf_fifo2.sv
// Two-entry FIFO with registered storage; the head entry is presented
// directly so it stays stable until popped.
module bmf_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push && (cnt != 2'd2);
    assign pop_ok  = pop && (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push_ok) - 2'(pop_ok);
        end
    end

    assign dout  = mem[rd_ptr];
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/abs_diff_bmf_decoder.sv
// Boolean matrix factorisation decoder: ORs the basis rows selected by each
// factor word into a 2-deep output FIFO, with shadowed basis updates.
module abs_diff_bmf_decoder
    import abs_diff_bmf_pkg::*;
#(
    parameter int unsigned K = BMF_K,
    parameter int unsigned M = BMF_M
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [K-1:0]                        in_k,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [M-1:0]                        out_po,
    input  logic                                cfg_we,
    input  logic [$clog2(K > 1 ? K : 2)-1:0]    cfg_row,
    input  logic [M-1:0]                        cfg_data,
    input  logic                                cfg_commit,
    output logic                                busy
);

    bmf_state_t state;
    logic [M-1:0] active     [K];
    logic [M-1:0] shadow     [K];
    logic [M-1:0] shadow_nxt [K];
    logic [M-1:0] product;
    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic         push;
    logic         pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;
    assign count_nxt = count + 2'(push) - 2'(pop);

    // Same-cycle row write is folded in here so a swap picks it up.
    always_comb begin
        shadow_nxt = shadow;
        for (int unsigned i = 0; i < K; i++) begin
            if (cfg_we && (32'(cfg_row) == i)) shadow_nxt[i] = cfg_data;
        end
    end

    always_comb begin
        product = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (in_k[i]) product = product | active[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            for (int unsigned i = 0; i < K; i++) begin
                active[i] <= M'(bmf_default_row(i));
                shadow[i] <= M'(bmf_default_row(i));
            end
        end else begin
            shadow <= shadow_nxt;
            case (state)
                ST_RUN: begin
                    if (cfg_commit) begin
                        state    <= ST_DRAIN;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        busy     <= 1'b0;
                        in_ready <= (count_nxt < 2'd2);
                    end
                end
                ST_DRAIN: begin
                    // Input is held off in DRAIN, so an empty FIFO here stays empty.
                    if (count == 2'd0) begin
                        active   <= shadow_nxt;
                        state    <= ST_RUN;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    bmf_fifo2 #(.W(M)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (product),
        .pop   (pop),
        .dout  (out_po),
        .valid (out_valid),
        .count (count)
    );

endmodule

// File: tb/tb_abs_diff_bmf_decoder.sv
// Directed bench for abs_diff_bmf_decoder with a small scoreboard.
module tb_abs_diff_bmf_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_k = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_po;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_row = '0;
    logic [4:0] cfg_data = '0;
    logic       cfg_commit = 1'b0;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int nacc = 0;
    int npop = 0;
    logic [4:0] q[$];
    logic [4:0] mrow0;
    logic [4:0] mrow1;

    typedef struct {
        logic [1:0] k;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[4];

    abs_diff_bmf_decoder #(.K(2), .M(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_k       (in_k),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_po     (out_po),
        .cfg_we     (cfg_we),
        .cfg_row    (cfg_row),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model(input logic [1:0] k);
        logic [4:0] r;
        r = '0;
        if (k[0]) r = r | mrow0;
        if (k[1]) r = r | mrow1;
        return r;
    endfunction

    // One clock: score the pop/push that happens at the coming edge.
    task automatic cycle();
        logic acc;
        logic pp;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        chk("valid_vs_model", out_valid, (q.size() != 0));
        if (pp && q.size() > 0) begin
            chk("sb_data", out_po, q[0]);
            void'(q.pop_front());
            npop++;
        end
        if (acc) begin
            q.push_back(model(in_k));
            nacc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        q.delete();
        mrow0 = 5'b01101;
        mrow1 = 5'b10000;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_po", out_po, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);
    endtask

    task automatic run_table();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_k = tbl[i].k;
            chk("tbl_in_ready", in_ready, 1'b1);
            cycle();
            chk("tbl_out_valid", out_valid, 1'b1);
            chk("tbl_out_po", out_po, tbl[i].exp);
        end
        in_valid = 1'b0;
        cycle();
        chk("tbl_drained", out_valid, 1'b0);
    endtask

    initial begin
        int p0;
        tbl[0] = '{k: 2'b01, exp: 5'b01101};
        tbl[1] = '{k: 2'b10, exp: 5'b10000};
        tbl[2] = '{k: 2'b11, exp: 5'b11101};
        tbl[3] = '{k: 2'b00, exp: 5'b00000};

        #1;
        apply_reset();
        run_table();

        // Backpressure
        out_ready = 1'b0;
        p0 = npop;
        in_valid = 1'b1;
        in_k = 2'b01;
        cycle();
        chk("bp_ready_1", in_ready, 1'b1);
        in_k = 2'b10;
        cycle();
        chk("bp_ready_full", in_ready, 1'b0);
        in_k = 2'b11;
        cycle();
        cycle();
        chk("bp_hold_head", out_po, 5'b01101);
        chk("bp_still_full", in_ready, 1'b0);
        out_ready = 1'b1;
        chk("bp_first_out", out_po, 5'b01101);
        cycle();
        chk("bp_second_out", out_po, 5'b10000);
        cycle();
        in_valid = 1'b0;
        chk("bp_third_out", out_po, 5'b11101);
        cycle();
        chk("bp_all_out", npop - p0, 3);
        chk("bp_empty", out_valid, 1'b0);

        // Commit with two words queued
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_k = 2'b01;
        cycle();
        in_k = 2'b10;
        cycle();
        in_valid = 1'b0;
        cfg_we = 1'b1;
        cfg_row = 1'b0;
        cfg_data = 5'b00011;
        cfg_commit = 1'b1;
        cycle();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        chk("drain_busy", busy, 1'b1);
        chk("drain_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        chk("drain_old0", out_po, 5'b01101);
        cycle();
        chk("drain_busy_mid", busy, 1'b1);
        chk("drain_old1", out_po, 5'b10000);
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
        chk("drain_empty_busy", busy, 1'b1);
        chk("drain_empty_ready", in_ready, 1'b0);
        cycle();
        chk("swap_busy", busy, 1'b0);
        chk("swap_ready", in_ready, 1'b1);
        mrow0 = 5'b00011;
        cycle();
        chk("commit_ignored_in_drain", busy, 1'b0);
        in_valid = 1'b1;
        in_k = 2'b01;
        cycle();
        in_valid = 1'b0;
        chk("post_commit", out_po, 5'b00011);
        cycle();

        // Shadow write in RUN leaves the active basis alone
        cfg_we = 1'b1;
        cfg_row = 1'b0;
        cfg_data = 5'b11111;
        cycle();
        cfg_we = 1'b0;
        in_valid = 1'b1;
        in_k = 2'b01;
        cycle();
        in_valid = 1'b0;
        chk("shadow_not_active", out_po, 5'b00011);
        cycle();

        // Row write on the swap cycle (restores row0 to 00011 as well)
        cfg_we = 1'b1;
        cfg_row = 1'b0;
        cfg_data = 5'b00011;
        cycle();
        cfg_we = 1'b0;
        in_valid = 1'b1;
        in_k = 2'b10;
        cfg_commit = 1'b1;
        cycle();
        in_valid = 1'b0;
        cfg_commit = 1'b0;
        chk("sc_busy", busy, 1'b1);
        for (int n = 0; n < 8 && out_valid; n++) cycle();
        chk("sc_empty", out_valid, 1'b0);
        chk("sc_still_busy", busy, 1'b1);
        cfg_we = 1'b1;
        cfg_row = 1'b1;
        cfg_data = 5'b01010;
        cycle();
        cfg_we = 1'b0;
        chk("sc_run", busy, 1'b0);
        mrow1 = 5'b01010;
        in_valid = 1'b1;
        in_k = 2'b11;
        cycle();
        in_valid = 1'b0;
        chk("sc_new_row1", out_po, 5'b01011);
        cycle();

        // Shadow row0 gets a non-default value, then reset mid-stream
        cfg_we = 1'b1;
        cfg_row = 1'b0;
        cfg_data = 5'b11111;
        cycle();
        cfg_we = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_k = 2'b11;
        cycle();
        in_k = 2'b10;
        cycle();
        in_valid = 1'b0;
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_valid", out_valid, 1'b1);
        apply_reset();
        // A commit now must copy the restored default shadow
        out_ready = 1'b1;
        cfg_commit = 1'b1;
        cycle();
        cfg_commit = 1'b0;
        cycle();
        chk("rst_commit_done", busy, 1'b0);
        run_table();

        // Streaming
        out_ready = 1'b1;
        p0 = nacc;
        in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_k = 2'($urandom_range(0, 3));
            if (in_ready !== 1'b1) chk("stream_in_ready", in_ready, 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("stream_count", nacc - p0, 1000);
        chk("stream_empty", out_valid, 1'b0);
        chk("stream_sb_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abs_diff_bmf_decoder.md
ABS_DIFF_BMF_DECODER -- requirements
Module: abs_diff_bmf_decoder

Interface
REQ-001 Parameters SHALL be: K, default 2, number of BMF factor bits; M, default 5, number of reconstructed output bits.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, reset; it is asynchronous and active-low.
REQ-004 Port in_valid SHALL be: input, 1 bit, factor word valid.
REQ-005 Port in_ready SHALL be: output, 1 bit, factor word accepted when in_valid && in_ready.
REQ-006 Port in_k SHALL be: input, K bits, factor vector; in_k[0] is k0.
REQ-007 Port out_valid SHALL be: output, 1 bit, reconstructed word valid.
REQ-008 Port out_ready SHALL be: input, 1 bit, downstream accept.
REQ-009 Port out_po SHALL be: output, M bits, reconstructed word; out_po[0] is po0.
REQ-010 Port cfg_we SHALL be: input, 1 bit, write one basis row into the shadow matrix.
REQ-011 Port cfg_row SHALL be: input, clog2(K) bits, basis row index.
REQ-012 Port cfg_data SHALL be: input, M bits, basis row contents.
REQ-013 Port cfg_commit SHALL be: input, 1 bit, request shadow-to-active swap.
REQ-014 Port busy SHALL be: output, 1 bit, high while a commit is pending.

Function
REQ-015 Each output word SHALL be the Boolean product out_po = OR over i of (in_k[i] AND H_active[i]), computed with the active matrix at the time the input is accepted.
REQ-016 Accepted words SHALL enter a 2-entry output FIFO; latency from acceptance to out_valid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-017 in_ready SHALL be high only when the FIFO holds fewer than 2 entries and the state is RUN; it SHALL NOT depend combinationally on out_ready.
REQ-018 out_valid SHALL be high whenever the FIFO is non-empty; out_po SHALL hold the head entry stable until out_valid && out_ready.
REQ-019 Simultaneous push and pop SHALL keep the FIFO count unchanged and preserve order; sustained throughput SHALL be 1 word per cycle when out_ready is held high.
REQ-020 cfg_we SHALL write cfg_data into the shadow row cfg_row in any state; a cfg_row value >= K SHALL be ignored.
REQ-021 The FSM SHALL have the states RUN and DRAIN.
REQ-022 In RUN, a cfg_commit SHALL move the FSM to DRAIN.
REQ-023 In DRAIN, in_ready SHALL be 0 and busy SHALL be 1.
REQ-024 When the FIFO becomes empty in DRAIN, the shadow matrix SHALL be copied to the active matrix and the FSM SHALL return to RUN in the same cycle.
REQ-025 A cfg_we and a swap in the same cycle SHALL take the new row into the active matrix.
REQ-026 cfg_commit in DRAIN SHALL be ignored.
REQ-027 Words already in the FIFO SHALL never be recomputed with a new matrix.

Reset
REQ-028 While rst_n is low, the following SHALL hold: FIFO empty, out_valid 0, out_po 0, busy 0, state RUN.
REQ-029 While rst_n is low, the active and shadow matrices SHALL both hold the default basis: row0 = 5'b01101 (po0, po2, po3) and row1 = 5'b10000 (po4); any rows above 1 SHALL be 0.
REQ-030 After rst_n is released, in_ready SHALL be 1 from the first clock edge.
REQ-031 Reset asserted mid-operation SHALL discard FIFO contents and any pending commit.

Structure
REQ-032 The parameters K and M, the FSM state enum, and the default basis constant SHALL live in a shared package, abs_diff_bmf_pkg.
REQ-033 The 2-entry FIFO SHALL be a separate sub-module, bmf_fifo2, parameterised by width.

Verification
REQ-034 Directed test, reset default: after reset, send in_k = 2'b01, 2'b10, 2'b11, 2'b00 with out_ready = 1 -> out_po = 5'b01101, 5'b10000, 5'b11101, 5'b00000, each one cycle after its acceptance.
REQ-035 Directed test, backpressure: with out_ready = 0, send 3 words -> in_ready drops after 2 accepts, and out_po holds the first word; then raise out_ready -> all words emerge in order with none lost or duplicated.
REQ-036 Directed test, commit drain: with 2 words queued, write row0 = 5'b00011 and commit -> busy = 1 and in_ready = 0 until the FIFO empties; the queued words still use the old basis; the next in_k = 2'b01 -> out_po = 5'b00011.
REQ-037 Directed test, same-cycle write and swap: issue cfg_we to row1 on the exact cycle the FIFO empties in DRAIN -> the new row1 is active on return to RUN.
REQ-038 Directed test, reset mid-stream: assert rst_n low with the FIFO full and a commit pending -> out_valid = 0 and busy = 0 immediately, and the default basis is restored.
REQ-039 Directed test, streaming: out_ready held high with a random in_k for 1000 cycles -> one word per cycle, and a scoreboard against the Boolean product of REQ-015 matches every word.
